// File: rtl/detector_scheduler.sv
// Round-robin controller sharing one serial 0011010 detector among NREQ
// requesters: grants one, flushes the detector, shifts the word MSB-first
// and counts detector matches.
// Ports:
//   clk       rising-edge clock, shared with the detector
//   rst       asynchronous active-low reset
//   req       per-requester request level, sampled only in IDLE
//   req_data  flattened words, requester i at [i*WIDTH +: WIDTH]
//   grant     one-hot grant, held for the whole transaction
//   busy      high whenever not IDLE
//   done      one-cycle pulse ending a transaction
//   hit_count matches counted in the last word (saturating)
//   det_x     serial bit to the detector
//   det_rst   synchronous active-high reset to the detector
//   det_y     registered match output of the detector
module detector_scheduler #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      hit_count,
  output logic                  det_x,
  output logic                  det_rst,
  input  logic                  det_y
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PMAX = PW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               sel_vld;
  logic [PW-1:0]      sel_idx;
  logic               sample;

  // Search from the farthest slot towards the pointer so the
  // nearest set request (at or after ptr, wrapping) wins.
  always_comb begin : arb
    int j;
    j       = 0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[PW'(j)]) begin
        sel_vld = 1'b1;
        sel_idx = PW'(j);
      end
    end
  end

  // det_y is registered in the detector, so each bit's verdict
  // appears one cycle later: skip the first SHIFT cycle, take DRAIN.
  assign sample = ((state_q == S_SHIFT) && (bcnt_q != '0)) ||
                  (state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    if (sample && det_y && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          sreg_d  = req_data[int'(sel_idx)*WIDTH +: WIDTH];
          cnt_d   = '0;
          ptr_d   = (sel_idx == PMAX) ? '0 : sel_idx + 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        bcnt_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign hit_count = cnt_q;
  assign det_x     = (state_q == S_SHIFT) && sreg_q[WIDTH-1];
  // Held in reset with us so the detector clears on every clock.
  assign det_rst   = !rst || (state_q == S_FLUSH);

endmodule

// File: tb/tb_detector_scheduler.sv
// Bench for detector_scheduler: behavioural detector, round-robin
// reference model with scoreboard, directed and random stimulus.
module tb_detector_scheduler;

  localparam int NREQ  = 2;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam logic [6:0] PAT = 7'b0011010;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      hit_count;
  logic                  det_x;
  logic                  det_rst;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External serial detector: registered match, sync reset,
  // overlapping detection, needs 7 bits since reset to match.
  logic [5:0] dh = '0;
  int         dn = 0;
  logic       dy = 1'b0;

  always @(posedge clk) begin
    if (det_rst) begin
      dh <= '0;
      dn <= 0;
      dy <= 1'b0;
    end else begin
      dh <= {dh[4:0], det_x};
      dn <= (dn < 6) ? dn + 1 : 6;
      dy <= (dn >= 6) && ({dh, det_x} == PAT);
    end
  end

  detector_scheduler #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .hit_count(hit_count),
    .det_x    (det_x),
    .det_rst  (det_rst),
    .det_y    (dy)
  );

  typedef struct {
    logic [NREQ-1:0]  g;
    logic [CNT_W-1:0] n;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int ref_hits(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    for (int i = 0; i + 7 <= WIDTH; i++) begin
      if (w[WIDTH-1-i -: 7] == PAT) n++;
    end
    if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] gen_word();
    logic [WIDTH-1:0] w;
    int s;
    w = WIDTH'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      s = $urandom_range(0, WIDTH - 7);
      w[WIDTH-1-s -: 7] = PAT;
    end
    return w;
  endfunction

  // Reference model. m_c counts cycles since the grant edge:
  // 0 flush, 1..WIDTH bits MSB first, WIDTH+1 drain, WIDTH+2 done.
  int               m_c    = -1;
  int               m_ptr  = 0;
  logic [NREQ-1:0]  m_g    = '0;
  logic [WIDTH-1:0] m_w    = '0;
  int               m_cnt  = 0;
  int               m_last = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_hits", 32'(hit_count), 32'(0));
      chk("rst_det_x", 32'(det_x), 32'(0));
      chk("rst_det_rst", 32'(det_rst), 32'(1));
      m_c    = -1;
      m_ptr  = 0;
      m_g    = '0;
      m_last = 0;
      sb.delete();
    end else begin
      chk("grant", 32'(grant), 32'((m_c >= 0) ? m_g : '0));
      chk("busy", 32'(busy), 32'(m_c >= 0));
      chk("done", 32'(done), 32'(m_c == WIDTH + 2));
      chk("det_rst", 32'(det_rst), 32'(m_c == 0));
      chk("det_x", 32'(det_x),
          32'((m_c >= 1 && m_c <= WIDTH) ? m_w[WIDTH-m_c] : 1'b0));
      if (m_c < 0) chk("idle_hits", 32'(hit_count), 32'(m_last));
      if (m_c == WIDTH + 2) begin
        m_c    = -1;
        m_last = m_cnt;
      end else if (m_c >= 0) begin
        m_c++;
      end else if (req != '0) begin
        int j;
        j = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (j < 0 && req[(m_ptr + k) % NREQ]) j = (m_ptr + k) % NREQ;
        end
        m_g   = NREQ'(1) << j;
        m_w   = req_data[j*WIDTH +: WIDTH];
        m_cnt = ref_hits(m_w);
        m_ptr = (j + 1) % NREQ;
        sb.push_back('{g: m_g, n: CNT_W'(m_cnt)});
        m_c   = 0;
      end
    end
  end

  // Monitor: every done pulse consumes one scoreboard entry.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected at %0t: got done=1 expected none",
                 $time);
      end else begin
        e = sb.pop_front();
        chk("done_grant", 32'(grant), 32'(e.g));
        chk("done_hits", 32'(hit_count), 32'(e.n));
      end
    end
  end

  task automatic txn(input logic [NREQ-1:0] r,
                     input logic [WIDTH-1:0] d0,
                     input logic [WIDTH-1:0] d1);
    req_data = {d1, d0};
    req      = r;
    @(posedge clk);
    #1 req = '0;
    repeat (WIDTH + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t: got no end expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    txn(2'b01, 16'h3400, 16'h0000);
    txn(2'b01, 16'h34D0, 16'h0000);
    txn(2'b01, 16'hFFFF, 16'h0000);

    rst      = 1'b0;
    req      = 2'b11;
    req_data = {16'h34D0, 16'h3400};
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    repeat (2 * (WIDTH + 4)) @(posedge clk);
    #1 req = '0;
    repeat (WIDTH + 3) @(posedge clk);
    #1;

    req_data = {gen_word(), gen_word()};
    req      = 2'b01;
    @(posedge clk);
    #1 req = '0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_data = {16'h34D0, gen_word()};
    req      = 2'b10;
    rst      = 1'b1;
    @(posedge clk);
    #1 req = '0;
    repeat (WIDTH + 3) @(posedge clk);
    #1;

    req_data = {16'h3400, 16'h34D0};
    req      = 2'b01;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 req = 2'b10;
    repeat (WIDTH - 1) @(posedge clk);
    #1 req = '0;
    repeat (WIDTH + 3) @(posedge clk);
    #1;

    for (int it = 0; it < 30; it++) begin
      req_data = {gen_word(), gen_word()};
      req      = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      repeat ($urandom_range(1, 30)) @(posedge clk);
      #1;
    end

    req = '0;
    repeat (WIDTH + 6) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/detector_scheduler.md
Name: detector_scheduler

Overview:
- Round-robin controller that shares one external serial sequence detector (pattern 0011010) among NREQ requesters.
- Each requester presents a parallel WIDTH-bit word. The block grants one requester, flushes the detector, and shifts the word MSB-first into it.
- It counts the detector's match outputs and returns the count with a one-cycle done pulse.
- It sits between the frame sources and the detector instance. The detector has a synchronous active-high reset, a serial input and a registered match output.

Parameters:
- NREQ, 2, number of requesters (2..4).
- WIDTH, 16, bits per word shifted into the detector.
- CNT_W, 5, hit counter width; must be at least clog2(WIDTH+1).

Ports:
- clk  input  1  rising-edge clock shared with the detector.
- rst  input  1  asynchronous active-low reset (0 = reset).
- req  input  NREQ  per-requester request level.
- req_data  input  NREQ*WIDTH  flattened words; requester i occupies [i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot grant, held for the whole transaction.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse ending a transaction.
- hit_count  output  CNT_W  number of detector matches in the last word.
- det_x  output  1  serial bit driven to the detector's x input.
- det_rst  output  1  synchronous active-high reset driven to the detector.
- det_y  input  1  detector match output, registered inside the detector.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE, grant=0, busy=0, done=0, hit_count=0, det_x=0.
  - Round-robin pointer=0.
  - det_rst=1 for as long as rst=0, so the detector clears on every clock during reset.
- Reset mid-transaction: the transaction is abandoned with no done pulse. After release the block re-arbitrates from pointer 0.
- All other logic updates on the rising edge of clk.
- States: IDLE, FLUSH, SHIFT, DRAIN, DONE.
- IDLE:
  - det_rst=0.
  - If any req bit is set: grant the first set bit at or after the pointer, wrapping modulo NREQ.
  - On that same edge: latch the granted word into a WIDTH-bit shift register, clear hit_count, go to FLUSH.
  - Pointer becomes granted index+1 mod NREQ.
- FLUSH (1 cycle): det_rst=1, det_x=0. Go to SHIFT.
- SHIFT (WIDTH cycles):
  - det_x = shift register MSB; the register shifts left each cycle.
  - A bit counter runs 0..WIDTH-1; go to DRAIN after the last bit.
- Hit sampling:
  - det_y is sampled in every SHIFT cycle except the first, and in DRAIN.
  - That is exactly WIDTH samples, each aligned one cycle after its bit.
  - hit_count increments on each sampled det_y=1 and saturates at 2^CNT_W-1.
- DRAIN (1 cycle): det_x=0, final sample taken. Go to DONE.
- DONE (1 cycle):
  - done=1, grant still asserted, hit_count final.
  - Next edge: grant=0, go to IDLE.
  - hit_count holds until the next grant.
- Transaction length from grant edge to done: 1+WIDTH+1 cycles. done is asserted WIDTH+2 cycles after the grant edge.
- No IDLE bubble is required beyond the single IDLE cycle after DONE.
- Request rules:
  - req is sampled only in IDLE. Deasserting or reasserting req during a transaction has no effect.
  - A requester that keeps req high after done is re-arbitrated behind the other requesters.
- Simultaneous requests are resolved only by the pointer; there is no fixed priority beyond reset pointer 0.
- Overlapping matches are counted exactly as the detector reports them. The controller does no pattern logic itself.

Test Plan:
- Reset with req=0: rst low for 3 cycles, then high.
  - Required: grant=0, busy=0, done=0, hit_count=0, det_x=0, det_rst=1 during reset and 0 after.
- req=2'b01, data0=16'h3400 (single 0011010 at the MSB end).
  - Required: grant=01 for 19 cycles, det_rst pulses once, det_x sequence 0,0,1,1,0,1,0,0,... (MSB first).
  - Required: done 18 cycles after the grant edge, hit_count=1.
- req=2'b01, data0=16'h34D0 (overlapping 0011010011010).
  - Required: hit_count=2.
  - Then data0=16'hFFFF, required: hit_count=0, which also proves the FLUSH cleared the previous detector state.
- req=2'b11 held from reset, data0=16'h3400, data1=16'h34D0.
  - Required: grant sequence 01, 10, 01; done results 1, 2, 1.
  - Required: the pointer alternates and neither requester is starved.
- Mid-transaction reset: rst low during the 6th SHIFT cycle.
  - Required: immediate grant=0, busy=0, no done, det_rst=1.
  - After release with req=2'b10, required: grant=10 and a correct count.
- Request change during SHIFT: drop req0 and raise req1 mid-word.
  - Required: the current transaction completes with grant=01 and done.
  - Required: req1 is granted in the following IDLE cycle.
